helen_ram_logger: RTL and testbench

Streaming write front-end for the 4096 x 32 single-port on-chip RAM. It accepts 32-bit samples on a valid/ready stream, buffers them in a small FIFO, and issues one Avalon-style write per clock into the RAM's data port. The RAM is filled either as a linear log or as a circular buffer. The block sits directly upstream of the on-chip RAM slave and drives its address, byteenable, chipselect, write and writedata inputs.

---
 rtl/helen_ram_logger.sv | 226 ++++++++++++++++++++++
 tb/tb_helen_ram_logger.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/helen_ram_logger.sv
// helen_ram_logger: streaming write front-end for a 2**ADDR_W x 32 single-port RAM.
//
// Samples arrive on a valid/ready stream, are buffered in a FIFO_DEPTH-entry
// FIFO, and leave as one Avalon-style write per clock toward the RAM slave.
// The RAM is filled either as a linear log (halts when full) or as a
// circular buffer (overwrites the oldest data).
//
// Ports
//   clk, reset_n      single clock, asynchronous active-low reset
//   in_valid/in_data  input sample stream; in_ready is registered
//   enable            0 pauses RAM writes while the FIFO keeps filling
//   clear             single-cycle synchronous restart
//   wrap_en           1 = circular buffer, 0 = linear log
//   mem_stall         1 = no write issued on the next cycle
//   m_*               registered RAM write port (address/byteenable/cs/write/data)
//   wr_ptr, count     next RAM address; valid words (saturates at 2**ADDR_W)
//   full              linear log has filled the RAM and halted
//   wrapped           sticky: wr_ptr rolled over at least once
//   overflow, dropped sticky drop flag; saturating drop counter
module helen_ram_logger #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  input  logic              enable,
  input  logic              clear,
  input  logic              wrap_en,
  input  logic              mem_stall,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              wrapped,
  output logic              overflow,
  output logic [15:0]       dropped
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned SUM_W  = DROP_W + 1;

  localparam logic [CNT_W-1:0]  RAM_WORDS     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR     = '1;
  localparam logic [OCC_W-1:0]  FIFO_FULL_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [BE_W-1:0]   BE_ALL        = '1;

  // FIFO state
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [PTR_W-1:0]  fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic [OCC_W-1:0]  fifo_occ_q, fifo_occ_d;

  // Registered outputs
  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [BE_W-1:0]   m_byteenable_q, m_byteenable_d;
  logic              m_write_q, m_write_d;
  logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              wrapped_q, wrapped_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;

  // Per-cycle decisions
  logic              fifo_empty_c;
  logic              accept_c;
  logic              issue_c;
  logic              drain_c;
  logic              push_c;
  logic              pop_c;
  logic [1:0]        drop_inc_c;
  logic [SUM_W-1:0]  dropped_sum_c;

  // Handshake, issue and discard decisions for this edge
  always_comb begin
    fifo_empty_c  = (fifo_occ_q == '0);
    accept_c      = in_valid & in_ready_q;
    issue_c       = !fifo_empty_c & enable & !mem_stall & !full_q & !clear;
    // While halted the FIFO head is thrown away one word per cycle, and a
    // freshly accepted sample is thrown away directly instead of queued.
    drain_c       = full_q & !fifo_empty_c & !clear;
    push_c        = accept_c & !full_q & !clear;
    pop_c         = issue_c | drain_c;
    drop_inc_c    = 2'(drain_c) + 2'(accept_c & full_q & !clear);
    dropped_sum_c = {1'b0, dropped_q} + SUM_W'(drop_inc_c);
  end

  // FIFO next state
  always_comb begin
    fifo_mem_d    = fifo_mem_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_occ_d    = fifo_occ_q;

    if (clear) begin
      fifo_rd_ptr_d = '0;
      fifo_wr_ptr_d = '0;
      fifo_occ_d    = '0;
    end else begin
      if (push_c) begin
        fifo_mem_d[fifo_wr_ptr_q] = in_data;
        fifo_wr_ptr_d             = fifo_wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        fifo_rd_ptr_d = fifo_rd_ptr_q + PTR_W'(1);
      end
      fifo_occ_d = fifo_occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
    end
  end

  // RAM write port and status next state
  always_comb begin
    m_address_d    = m_address_q;
    m_writedata_d  = m_writedata_q;
    m_byteenable_d = '0;
    m_write_d      = 1'b0;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    full_d         = full_q;
    wrapped_d      = wrapped_q;
    overflow_d     = overflow_q;
    dropped_d      = dropped_q;

    if (clear) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      full_d     = 1'b0;
      wrapped_d  = 1'b0;
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else begin
      if (issue_c) begin
        m_write_d      = 1'b1;
        m_byteenable_d = BE_ALL;
        m_address_d    = wr_ptr_q;
        m_writedata_d  = fifo_mem_q[fifo_rd_ptr_q];
        wr_ptr_d       = wr_ptr_q + ADDR_W'(1);
        if (wr_ptr_q == LAST_ADDR) begin
          wrapped_d = 1'b1;
        end
        if (count_q != RAM_WORDS) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      // Covers both the write to the last address and wrap_en falling
      // while the RAM already holds a full buffer.
      full_d = !wrap_en && (count_d == RAM_WORDS);
      if (drop_inc_c != 2'd0) begin
        overflow_d = 1'b1;
        dropped_d  = dropped_sum_c[SUM_W-1] ? '1 : dropped_sum_c[DROP_W-1:0];
      end
    end
  end

  // in_ready looks only at next-state occupancy, never at in_valid
  always_comb begin
    in_ready_d = full_d | (fifo_occ_d != FIFO_FULL_OCC);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_mem_q     <= '{default: '0};
      fifo_rd_ptr_q  <= '0;
      fifo_wr_ptr_q  <= '0;
      fifo_occ_q     <= '0;
      in_ready_q     <= 1'b0;
      m_address_q    <= '0;
      m_byteenable_q <= '0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      wrapped_q      <= 1'b0;
      overflow_q     <= 1'b0;
      dropped_q      <= '0;
    end else begin
      fifo_mem_q     <= fifo_mem_d;
      fifo_rd_ptr_q  <= fifo_rd_ptr_d;
      fifo_wr_ptr_q  <= fifo_wr_ptr_d;
      fifo_occ_q     <= fifo_occ_d;
      in_ready_q     <= in_ready_d;
      m_address_q    <= m_address_d;
      m_byteenable_q <= m_byteenable_d;
      m_write_q      <= m_write_d;
      m_writedata_q  <= m_writedata_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      wrapped_q      <= wrapped_d;
      overflow_q     <= overflow_d;
      dropped_q      <= dropped_d;
    end
  end

  // chipselect and write share one flop so they can never disagree
  assign in_ready     = in_ready_q;
  assign m_address    = m_address_q;
  assign m_byteenable = m_byteenable_q;
  assign m_chipselect = m_write_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_writedata_q;
  assign wr_ptr       = wr_ptr_q;
  assign count        = count_q;
  assign full         = full_q;
  assign wrapped      = wrapped_q;
  assign overflow     = overflow_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_helen_ram_logger.sv
// Scoreboard bench for helen_ram_logger: the driver predicts every RAM write
// (address, data) from the order of accepted samples; a monitor pops and
// compares whenever the write strobe is seen.
module tb_helen_ram_logger;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned RAM_WORDS  = 4096;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              wrap_en = 1'b0;
  logic              mem_stall = 1'b0;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              wrapped;
  logic              overflow;
  logic [15:0]       dropped;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;
  int unsigned n_sched = 0;
  int unsigned exp_dropped = 0;
  bit          model_wrap = 1'b0;
  bit          rand_mode = 1'b0;
  bit          mark_first = 1'b0;
  int          first_wr_cyc = 0;
  int          last_wr_cyc = 0;

  helen_ram_logger #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .enable(enable), .clear(clear), .wrap_en(wrap_en),
    .mem_stall(mem_stall), .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
    .wr_ptr(wr_ptr), .count(count), .full(full), .wrapped(wrapped),
    .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the n-th sample kept since the last clear goes to
  // address n mod 4096; a linear log keeps only the first 4096.
  function automatic void model_accept(input logic [31:0] d);
    wr_t w;
    if (!model_wrap && n_sched >= RAM_WORDS) begin
      if (exp_dropped < 65535) exp_dropped++;
    end else begin
      w.addr = ADDR_W'(n_sched % RAM_WORDS);
      w.data = d;
      sb_q.push_back(w);
      n_sched++;
    end
  endfunction

  function automatic void model_clear();
    sb_q.delete();
    n_sched     = 0;
    exp_dropped = 0;
  endfunction

  // Monitor: strobe consistency every cycle, scoreboard on every write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      chk("strobe_pair", {59'd0, m_chipselect, m_byteenable},
          m_write ? 64'h1F : 64'h00);
      if (m_write === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)",
                   m_address, m_writedata, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 64'(m_address), 64'(e.addr));
          chk("wr_data", 64'(m_writedata), 64'(e.data));
          if (mark_first) begin
            first_wr_cyc = cyc;
            mark_first   = 1'b0;
          end
          last_wr_cyc = cyc;
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] d, output int acc_edge);
    bit done;
    done     = 1'b0;
    acc_edge = -1;
    if (rand_mode && ($urandom_range(0, 3) == 0)) begin
      @(negedge clk);
      in_valid  = 1'b0;
      mem_stall = ($urandom_range(0, 5) == 0);
    end
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (rand_mode) mem_stall = ($urandom_range(0, 5) == 0);
      in_valid = 1'b1;
      in_data  = d;
      if (in_ready) begin
        model_accept(d);
        acc_edge = cyc + 1;
        done     = 1'b1;
      end
    end
    chk("push_accepted", 64'(done), 64'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid  = 1'b0;
    mem_stall = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
    repeat (FIFO_DEPTH + 4) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    int unsigned n_done;
    n_done = model_wrap ? n_sched : ((n_sched < RAM_WORDS) ? n_sched : RAM_WORDS);
    chk({tag, "_wr_ptr"}, 64'(wr_ptr), 64'(n_done % RAM_WORDS));
    chk({tag, "_count"}, 64'(count), 64'((n_done < RAM_WORDS) ? n_done : RAM_WORDS));
    chk({tag, "_wrapped"}, 64'(wrapped), 64'(n_done >= RAM_WORDS));
    chk({tag, "_full"}, 64'(full), 64'(!model_wrap && n_done >= RAM_WORDS));
    chk({tag, "_overflow"}, 64'(overflow), 64'(exp_dropped != 0));
    chk({tag, "_dropped"}, 64'(dropped), 64'(exp_dropped));
  endtask

  task automatic do_clear(input logic with_valid);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = with_valid;
    in_data  = 32'hDEAD_BEEF;
    model_clear();
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_no_strobe", 64'(m_write), 64'd0);
    check_status("clear");
    chk("clear_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int acc0;
    int acc_tmp;
    int accepts;

    // Reset and idle
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_m", {m_address, m_byteenable, m_chipselect, m_write}, 64'd0);
    chk("rst_wdata", 64'(m_writedata), 64'd0);
    chk("rst_status", {wr_ptr, count, full, wrapped, overflow, dropped}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    check_status("idle");

    // Burst of ten back-to-back samples
    enable     = 1'b1;
    mark_first = 1'b1;
    push_word(32'h1000, acc0);
    for (int i = 1; i < 10; i++) push_word(32'h1000 + 32'(i), acc_tmp);
    idle_cycle();
    wait_drain();
    chk("burst_latency", 64'(first_wr_cyc - acc0), 64'd1);
    chk("burst_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'd9);
    check_status("burst");

    // Backpressure with writes paused
    enable  = 1'b0;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h2000 + 32'(accepts);
      if (in_ready) begin
        model_accept(in_data);
        accepts++;
      end
    end
    idle_cycle();
    chk("bp_accepts", 64'(accepts), 64'd8);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    enable = 1'b1;
    for (int i = accepts; i < 10; i++) push_word(32'h2000 + 32'(i), acc_tmp);
    idle_cycle();
    wait_drain();
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    check_status("bp");

    // Linear fill past the end of the RAM
    do_clear(1'b0);
    wrap_en    = 1'b0;
    model_wrap = 1'b0;
    for (int i = 0; i < 4100; i++) push_word($urandom, acc_tmp);
    idle_cycle();
    wait_drain();
    check_status("linear");
    chk("linear_dropped4", 64'(dropped), 64'd4);
    chk("linear_in_ready_halted", 64'(in_ready), 64'd1);

    // Circular buffer with random gaps and stalls
    do_clear(1'b0);
    wrap_en    = 1'b1;
    model_wrap = 1'b1;
    rand_mode  = 1'b1;
    for (int i = 0; i < 4098; i++) push_word($urandom, acc_tmp);
    rand_mode = 1'b0;
    idle_cycle();
    wait_drain();
    check_status("circ");
    @(negedge clk);
    wrap_en = 1'b0;
    @(negedge clk);
    chk("wrapoff_full", 64'(full), 64'd1);
    chk("wrapoff_count", 64'(count), 64'(RAM_WORDS));
    wrap_en = 1'b1;

    // Stall mid-burst, then clear with data queued and in_valid high
    do_clear(1'b0);
    wrap_en    = 1'b0;
    model_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) mem_stall = 1'b1;
      if (i == 9) mem_stall = 1'b0;
      push_word(32'h3000 + 32'(i), acc_tmp);
    end
    idle_cycle();
    wait_drain();
    check_status("stall");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h4000 + 32'(i), acc_tmp);
    do_clear(1'b1);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check_status("post_clear");
    for (int i = 0; i < 2; i++) push_word(32'h5000 + 32'(i), acc_tmp);
    idle_cycle();
    wait_drain();
    check_status("post_clear_push");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
